// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// Memory stage of the pipeline. It consumes the registered EX/MEM bundle and
// performs any load or store over a req/ack data-memory bus. While an access
// is outstanding it raises stall, which freezes EX/MEM (EX/MEM EN = ~stall).
// It registers the MEM/WB bundle for the write-back stage.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   When defined, a misaligned half or word access never reaches the bus. It
//   completes in one cycle with RegWrite cleared and the extra registered
//   output `misalign` set. When undefined, the low address bits below the
//   access size are ignored.
//
// Parameters
//   BIG_ENDIAN  0: byte lane = addr[1:0]; 1: byte lane = 3 - addr[1:0]
//
// Ports
//   clk, CLR                 clock, synchronous active-high reset
//   In + *_in                EX/MEM valid and bundle (R1_in is the memory address)
//   stall                    combinational hold request for EX/MEM
//   mem_req/we/addr/be/wdata registered data-memory request
//   mem_ack, mem_rdata       completion and load data (rdata valid with ack)
//   Out + IR..MemtoReg       registered MEM/WB bundle; MemData = extended load data
//   misalign                 (MEM_ALIGN_CHECK_EN only) registered with Out
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int BIG_ENDIAN = 0
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        In,
  input  logic [31:0] IR_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] R1_in,
  input  logic [31:0] R2_in,
  input  logic [31:0] RD2_in,
  input  logic [4:0]  WbRegNum_in,
  input  logic        RegWrite_in,
  input  logic        LOWrite_in,
  input  logic        HIWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic        UnsignedExt_Mem_in,
  input  logic        Byte_in,
  input  logic        Half_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        Out,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic [31:0] R1,
  output logic [31:0] R2,
  output logic [31:0] MemData,
  output logic [4:0]  WbRegNum,
  output logic        RegWrite,
  output logic        LOWrite,
  output logic        HIWrite,
  output logic        MemtoReg
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wb;
    logic        rw;
    logic        lo;
    logic        hi;
    logic        m2r;
    logic        uns;
    logic        by;
    logic        hf;
  } bundle_t;

  // Byte lane addressed by a[1:0] under the configured endianness.
  function automatic logic [1:0] byte_lane(input logic [1:0] a);
    if (BIG_ENDIAN != 0) begin
      byte_lane = 2'd3 - a;
    end else begin
      byte_lane = a;
    end
  endfunction

  // 1 when the addressed halfword sits in the upper 16 bits of the bus.
  function automatic logic half_hi(input logic a1);
    if (BIG_ENDIAN != 0) begin
      half_hi = ~a1;
    end else begin
      half_hi = a1;
    end
  endfunction

  // Lane extraction plus sign/zero extension; Byte takes priority over Half.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] a,
                                               input logic is_byte, input logic is_half,
                                               input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (byte_lane(a))
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = half_hi(a[1]) ? rdata[31:16] : rdata[15:0];
    if (is_byte) begin
      load_extract = uns ? {24'h000000, b} : {{24{b[7]}}, b};
    end else if (is_half) begin
      load_extract = uns ? {16'h0000, h} : {{16{h[15]}}, h};
    end else begin
      load_extract = rdata;
    end
  endfunction

  state_t      state_r, state_nx_s;
  bundle_t     in_s, sv_r, src_s;
  logic        memop_s, misal_s, launch_s, complete_s, pass_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  assign in_s = '{ir: IR_in, pc: PC_in, r1: R1_in, r2: R2_in, wb: WbRegNum_in,
                  rw: RegWrite_in, lo: LOWrite_in, hi: HIWrite_in, m2r: MemtoReg_in,
                  uns: UnsignedExt_Mem_in, by: Byte_in, hf: Half_in};

  assign memop_s = In & (MemWrite_in | MemtoReg_in);

`ifdef MEM_ALIGN_CHECK_EN
  assign misal_s = memop_s & ~Byte_in & (Half_in ? R1_in[0] : (R1_in[1:0] != 2'b00));
`else
  assign misal_s = 1'b0;
`endif

  // MEM/WB source: the saved bundle on bus completion, otherwise the live EX/MEM bundle.
  assign src_s = complete_s ? sv_r : in_s;

  // Byte enables and lane-replicated store data for the current EX/MEM access.
  always_comb begin
    if (Byte_in) begin
      be_s    = 4'b0001 << byte_lane(R1_in[1:0]);
      wdata_s = {4{RD2_in[7:0]}};
    end else if (Half_in) begin
      be_s    = half_hi(R1_in[1]) ? 4'b1100 : 4'b0011;
      wdata_s = {2{RD2_in[15:0]}};
    end else begin
      be_s    = 4'hF;
      wdata_s = RD2_in;
    end
  end

  // FSM next state, stall and the one-cycle launch/complete/pass-through strobes.
  always_comb begin
    state_nx_s = state_r;
    stall      = 1'b0;
    launch_s   = 1'b0;
    complete_s = 1'b0;
    pass_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (memop_s && !misal_s) begin
          stall      = 1'b1;
          launch_s   = 1'b1;
          state_nx_s = BUSY;
        end else begin
          pass_s = In;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          complete_s = 1'b1;
          state_nx_s = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nx_s = IDLE;
    endcase
    if (CLR) begin
      state_nx_s = IDLE;
      stall      = 1'b0;
      launch_s   = 1'b0;
      complete_s = 1'b0;
      pass_s     = 1'b0;
    end else begin
      state_nx_s = state_nx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Bus request registers and saved bundle; held stable for the whole BUSY period.
  always_ff @(posedge clk) begin
    if (CLR) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      sv_r      <= '0;
    end else if (launch_s) begin
      mem_req   <= 1'b1;
      mem_we    <= MemWrite_in;
      mem_addr  <= {R1_in[31:2], 2'b00};
      mem_be    <= be_s;
      mem_wdata <= wdata_s;
      sv_r      <= in_s;
    end else if (complete_s) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      mem_req   <= mem_req;
    end
  end

  // MEM/WB register: valid bundle on completion or pass-through, bubble otherwise.
  always_ff @(posedge clk) begin
    if (CLR || !(complete_s || pass_s)) begin
      Out      <= 1'b0;
      IR       <= 32'h0;
      PC       <= 32'h0;
      R1       <= 32'h0;
      R2       <= 32'h0;
      MemData  <= 32'h0;
      WbRegNum <= 5'd0;
      RegWrite <= 1'b0;
      LOWrite  <= 1'b0;
      HIWrite  <= 1'b0;
      MemtoReg <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
    end else begin
      Out      <= 1'b1;
      IR       <= src_s.ir;
      PC       <= src_s.pc;
      R1       <= src_s.r1;
      R2       <= src_s.r2;
      MemData  <= (complete_s && src_s.m2r) ?
                  load_extract(mem_rdata, src_s.r1[1:0], src_s.by, src_s.hf, src_s.uns) : 32'h0;
      WbRegNum <= src_s.wb;
      // A misaligned access completes here without ever touching the bus.
      RegWrite <= src_s.rw & ~(pass_s & misal_s);
      LOWrite  <= src_s.lo;
      HIWrite  <= src_s.hi;
      MemtoReg <= src_s.m2r;
`ifdef MEM_ALIGN_CHECK_EN
      misalign <= pass_s & misal_s;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        CLR, In;
  logic [31:0] IR_in, PC_in, R1_in, R2_in, RD2_in;
  logic [4:0]  WbRegNum_in;
  logic        RegWrite_in, LOWrite_in, HIWrite_in, MemtoReg_in;
  logic        MemWrite_in, UnsignedExt_Mem_in, Byte_in, Half_in;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        Out, RegWrite, LOWrite, HIWrite, MemtoReg;
  logic [31:0] IR, PC, R1, R2, MemData;
  logic [4:0]  WbRegNum;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  typedef struct {
    logic [31:0] ir, pc, r1, r2, md;
    logic [4:0]  wb;
    logic        rw, m2r, mis;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_v = 32'h0000_1000;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .CLR(CLR), .In(In), .IR_in(IR_in), .PC_in(PC_in), .R1_in(R1_in),
    .R2_in(R2_in), .RD2_in(RD2_in), .WbRegNum_in(WbRegNum_in), .RegWrite_in(RegWrite_in),
    .LOWrite_in(LOWrite_in), .HIWrite_in(HIWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemWrite_in(MemWrite_in), .UnsignedExt_Mem_in(UnsignedExt_Mem_in), .Byte_in(Byte_in),
    .Half_in(Half_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .Out(Out), .IR(IR), .PC(PC), .R1(R1), .R2(R2),
    .MemData(MemData), .WbRegNum(WbRegNum), .RegWrite(RegWrite), .LOWrite(LOWrite),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .HIWrite(HIWrite), .MemtoReg(MemtoReg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid MEM/WB output pops the oldest expected entry.
  always @(negedge clk) begin
    if (Out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got Out=1 expected no output (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_IR", IR, mon_e.ir);
        chk("wb_PC", PC, mon_e.pc);
        chk("wb_R1", R1, mon_e.r1);
        chk("wb_R2", R2, mon_e.r2);
        chk("wb_MemData", MemData, mon_e.md);
        chk("wb_WbRegNum", 32'(WbRegNum), 32'(mon_e.wb));
        chk("wb_RegWrite", 32'(RegWrite), 32'(mon_e.rw));
        chk("wb_MemtoReg", 32'(MemtoReg), 32'(mon_e.m2r));
`ifdef MEM_ALIGN_CHECK_EN
        chk("wb_misalign", 32'(misalign), 32'(mon_e.mis));
`endif
      end
    end
  end

  // Drive one EX/MEM bundle, act as the memory (ack after `delay` waiting BUSY cycles),
  // hold the bundle while stalled, and check the bus outputs every BUSY cycle.
  // Called at posedge+1; returns at posedge+1 after the bundle was consumed.
  task automatic issue(input logic [31:0] ir, input logic [31:0] r1, input logic [31:0] rd2,
                       input logic rw, input logic m2r, input logic mw, input logic uns,
                       input logic by, input logic hf, input int delay,
                       input logic [31:0] rdata, input logic [31:0] exp_md,
                       input int exp_stalls, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic exp_rw, input logic exp_mis);
    int   stalls;
    int   busy;
    bit   done;
    exp_t e;
    stalls = 0;
    busy   = 0;
    done   = 1'b0;
    In = 1'b1; IR_in = ir; PC_in = pc_v; R1_in = r1; R2_in = ~r1; RD2_in = rd2;
    WbRegNum_in = ir[4:0]; RegWrite_in = rw; MemtoReg_in = m2r; MemWrite_in = mw;
    UnsignedExt_Mem_in = uns; Byte_in = by; Half_in = hf;
    e = '{ir: ir, pc: pc_v, r1: r1, r2: ~r1, md: exp_md, wb: ir[4:0],
          rw: exp_rw, m2r: m2r, mis: exp_mis};
    exp_q.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      mem_ack   = mem_req && (busy == delay);
      mem_rdata = mem_ack ? rdata : 32'h0;
      if (mem_req) begin
        chk("bus_we", 32'(mem_we), 32'(mw));
        chk("bus_addr", mem_addr, {r1[31:2], 2'b00});
        chk("bus_be", 32'(mem_be), 32'(exp_be));
        chk("bus_wdata", mem_wdata, exp_wd);
        busy++;
      end
      #1;
      if (stall) begin
        stalls++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got stall stuck expected release within 40 cycles");
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(posedge clk);
    #1;
    In = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    pc_v = pc_v + 32'd4;
  endtask

  initial begin
    CLR = 1'b1; In = 1'b0; IR_in = 32'h0; PC_in = 32'h0; R1_in = 32'h0; R2_in = 32'h0;
    RD2_in = 32'h0; WbRegNum_in = 5'd0; RegWrite_in = 1'b0; LOWrite_in = 1'b0;
    HIWrite_in = 1'b0; MemtoReg_in = 1'b0; MemWrite_in = 1'b0; UnsignedExt_Mem_in = 1'b0;
    Byte_in = 1'b0; Half_in = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    CLR = 1'b0;
    // Reset state
    chk("rst_Out", 32'(Out), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_MemData", MemData, 32'h0);
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);

    //     ir            r1            rd2           rw    m2r   mw    uns   by    hf    dly rdata         exp_md        stl be       wdata         exp_rw mis
    // ALU op
    issue(32'h0000_0821, 32'h0000_1234, 32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0,        32'h0,        0, 4'h0,    32'h0,        1'b1, 1'b0);
    // LB lane 3, ack after 3 waiting cycles
    issue(32'h8000_0102, 32'h0000_0103, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 32'h80FF_FFFF, 32'hFFFF_FF80, 4, 4'b1000, 32'h0,        1'b1, 1'b0);
    // LHU upper half
    issue(32'h9400_0103, 32'h0000_0102, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'hBEEF_1234, 32'h0000_BEEF, 1, 4'b1100, 32'h0,        1'b1, 1'b0);
    // SB lane 1
    issue(32'hA000_0004, 32'h0000_0201, 32'h0000_00AA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h0,     32'h0,        2, 4'b0010, 32'hAAAA_AAAA, 1'b0, 1'b0);
    // LW
    issue(32'h8C00_0105, 32'h0000_0300, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 4'hF,    32'h0,        1'b1, 1'b0);
    // LH signed lower half
    issue(32'h8400_0106, 32'h0000_0100, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h1234_8001, 32'hFFFF_8001, 1, 4'b0011, 32'h0,        1'b1, 1'b0);
    // LBU lane 2
    issue(32'h9000_0107, 32'h0000_0102, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 32'h00C3_0000, 32'h0000_00C3, 1, 4'b0100, 32'h0,        1'b1, 1'b0);
    // SH upper half, two waiting cycles
    issue(32'hA400_0008, 32'h0000_0402, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 32'h0,     32'h0,        3, 4'b1100, 32'h5678_5678, 1'b0, 1'b0);
    // SW
    issue(32'hAC00_0009, 32'h0000_0500, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0,     32'h0,        1, 4'hF,    32'hDEAD_BEEF, 1'b0, 1'b0);
    // Byte and Half both set: byte access wins
    issue(32'h8000_010A, 32'h0000_0101, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 32'h0000_7F00, 32'h0000_007F, 1, 4'b0010, 32'h0,        1'b1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned LW completes without a bus request
    issue(32'h8C00_010B, 32'h0000_0102, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0,        32'h0,        0, 4'hF,    32'h0,        1'b0, 1'b1);
    chk("misal_no_req", 32'(mem_req), 32'd0);
`else
    // Unaligned LW: low address bits ignored, full word access
    issue(32'h8C00_010B, 32'h0000_0102, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h1122_3344, 32'h1122_3344, 1, 4'hF,    32'h0,        1'b1, 1'b0);
`endif

    // Bubbles with In=0
    @(posedge clk);
    #1;
    chk("bubble_Out", 32'(Out), 32'd0);
    chk("bubble_stall", 32'(stall), 32'd0);

    // CLR in the middle of BUSY; the following ack is ignored
    In = 1'b1; IR_in = 32'h8C00_000C; R1_in = 32'h0000_0600; MemtoReg_in = 1'b1; RegWrite_in = 1'b1;
    MemWrite_in = 1'b0; Byte_in = 1'b0; Half_in = 1'b0; UnsignedExt_Mem_in = 1'b0;
    #1;
    chk("clr_pre_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    chk("clr_busy_req", 32'(mem_req), 32'd1);
    CLR = 1'b1;
    In  = 1'b0;
    #1;
    chk("clr_stall_low", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    CLR = 1'b0;
    chk("clr_mem_req", 32'(mem_req), 32'd0);
    chk("clr_mem_be", 32'(mem_be), 32'd0);
    chk("clr_Out", 32'(Out), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    #1;
    chk("clr_ack_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    chk("clr_ack_Out", 32'(Out), 32'd0);
    chk("clr_ack_req", 32'(mem_req), 32'd0);

    // Recovery after CLR
    issue(32'h0000_1025, 32'h0000_BEEF, 32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0,        32'h0,        0, 4'h0,    32'h0,        1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
